// File: rtl/linear_interp_scheduler_if.sv
// Handshake bundle between four sample producers, the interpolation
// scheduler and the downstream consumer of interpolated samples.
interface linear_interp_scheduler_if #(
    parameter int WORD_SIZE = 8
);
    logic [3:0]             in_valid;
    logic [4*WORD_SIZE-1:0] in_data;
    logic [3:0]             in_ready;
    logic                   out_valid;
    logic [WORD_SIZE-1:0]   out_data;
    logic [1:0]             out_chan;
    logic                   out_phase;
    logic                   out_ready;
    logic                   busy;

    // Scheduler side
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_chan,
        output out_phase,
        output busy
    );

    // Producer/consumer side
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_chan,
        input  out_phase,
        input  busy
    );
endinterface

// File: rtl/linear_interp_scheduler.sv
// Four-channel 2x linear interpolator: one shared midpoint datapath, a
// round-robin grant in IDLE, and a midpoint-then-sample output pair per input.
module linear_interp_scheduler #(
    parameter int WORD_SIZE = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    linear_interp_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MID  = 2'd1,
        ST_SAMP = 2'd2
    } state_t;

    state_t                 r_state;
    logic [1:0]             r_ptr;
    logic [WORD_SIZE-1:0]   r_prev [4];
    logic [WORD_SIZE-1:0]   r_sample;
    logic [1:0]             r_chan;
    logic                   r_out_valid;
    logic [WORD_SIZE-1:0]   r_out_data;
    logic [1:0]             r_out_chan;
    logic                   r_out_phase;
    logic                   r_busy;

    logic                   w_found;
    logic [1:0]             w_gidx;
    logic [3:0]             w_in_ready;
    logic [WORD_SIZE-1:0]   w_sel_data;
    logic [WORD_SIZE:0]     w_sum;
    logic [WORD_SIZE-1:0]   w_mid;

    // Round-robin search starting at r_ptr for the first requesting channel
    always_comb begin
        logic [1:0] cand;
        w_found = 1'b0;
        w_gidx  = 2'd0;
        cand    = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cand = r_ptr + 2'(k);
            if (!w_found && bus.in_valid[cand]) begin
                w_found = 1'b1;
                w_gidx  = cand;
            end else begin
                w_found = w_found;
            end
        end
    end

    // Grant is only offered while idle and out of reset
    always_comb begin
        w_in_ready = 4'b0000;
        if (!reset && (r_state == ST_IDLE) && w_found) begin
            w_in_ready = 4'b0001 << w_gidx;
        end else begin
            w_in_ready = 4'b0000;
        end
    end

    // Midpoint is formed one bit wider so the sum never wraps
    always_comb begin
        w_sel_data = bus.in_data[int'(w_gidx)*WORD_SIZE +: WORD_SIZE];
        w_sum      = {1'b0, r_prev[w_gidx]} + {1'b0, w_sel_data};
        w_mid      = w_sum[WORD_SIZE:1];
    end

    // Scheduler FSM with registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_ptr       <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                r_prev[i] <= '0;
            end
            r_sample    <= '0;
            r_chan      <= 2'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= 2'd0;
            r_out_phase <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_sample    <= w_sel_data;
                        r_chan      <= w_gidx;
                        r_out_data  <= w_mid;
                        r_out_chan  <= w_gidx;
                        r_out_phase <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ST_MID;
                    end else begin
                        r_state     <= ST_IDLE;
                    end
                end
                ST_MID: begin
                    if (bus.out_ready) begin
                        r_out_data  <= r_sample;
                        r_out_phase <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_SAMP;
                    end else begin
                        r_state     <= ST_MID;
                    end
                end
                ST_SAMP: begin
                    // prev is committed only once both outputs have been taken
                    if (bus.out_ready) begin
                        r_out_valid     <= 1'b0;
                        r_prev[r_chan]  <= r_sample;
                        r_ptr           <= r_chan + 2'd1;
                        r_busy          <= 1'b0;
                        r_state         <= ST_IDLE;
                    end else begin
                        r_state         <= ST_SAMP;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_chan  = r_out_chan;
    assign bus.out_phase = r_out_phase;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_linear_interp_scheduler.sv
// Directed bench for linear_interp_scheduler with hand-computed expected values.
module tb_linear_interp_scheduler;

    logic clock;
    logic reset;
    int   n_total;
    int   n_bad;

    linear_interp_scheduler_if #(.WORD_SIZE(8)) bus ();

    linear_interp_scheduler #(.WORD_SIZE(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset         = 1'b1;
        bus.in_valid  = 4'b0001;
        bus.out_ready = 1'b1;
        next_cycle();
        check_val("rst_in_ready", 32'(bus.in_ready), 32'd0);
        next_cycle();
        check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_val("rst_busy", 32'(bus.busy), 32'd0);
        check_val("rst_out_data", 32'(bus.out_data), 32'd0);
        reset        = 1'b0;
        bus.in_valid = 4'b0000;
    endtask

    // One full transaction on a single channel with out_ready held high
    task automatic send(input int ch, input logic [7:0] data, input logic [7:0] exp_mid);
        bus.in_valid              = 4'b0000;
        bus.in_valid[ch]          = 1'b1;
        bus.in_data[ch*8 +: 8]    = data;
        bus.out_ready             = 1'b1;
        #1;
        check_val("grant", 32'(bus.in_ready), 32'(4'b0001 << ch));
        next_cycle();
        bus.in_valid = 4'b0000;
        check_val("mid_valid", 32'(bus.out_valid), 32'd1);
        check_val("mid_chan", 32'(bus.out_chan), 32'(ch));
        check_val("mid_phase", 32'(bus.out_phase), 32'd0);
        check_val("mid_data", 32'(bus.out_data), 32'(exp_mid));
        check_val("mid_ready0", 32'(bus.in_ready), 32'd0);
        next_cycle();
        check_val("samp_phase", 32'(bus.out_phase), 32'd1);
        check_val("samp_data", 32'(bus.out_data), 32'(data));
        check_val("samp_valid", 32'(bus.out_valid), 32'd1);
        next_cycle();
        check_val("idle_valid", 32'(bus.out_valid), 32'd0);
        check_val("idle_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        n_total       = 0;
        n_bad         = 0;
        reset         = 1'b1;
        bus.in_valid  = 4'b0000;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;

        // Basic two-sample sequence on ch0
        apply_reset();
        send(0, 8'd100, 8'd50);
        send(0, 8'd200, 8'd150);

        // Round-robin with all channels requesting
        apply_reset();
        @(negedge clock);
        bus.in_data  = {8'd8, 8'd8, 8'd8, 8'd8};
        bus.in_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            check_val("rr_grant", 32'(bus.in_ready), 32'(4'b0001 << (k % 4)));
            next_cycle();
            check_val("rr_chan", 32'(bus.out_chan), 32'(k % 4));
            check_val("rr_mid", 32'(bus.out_data), (k == 4) ? 32'd8 : 32'd4);
            next_cycle();
            check_val("rr_samp", 32'(bus.out_data), 32'd8);
            next_cycle();
            check_val("rr_idle", 32'(bus.out_valid), 32'd0);
        end
        bus.in_valid = 4'b0000;

        // Stall on ch2 midpoint (prev[2]=8, new 20 -> 14)
        bus.in_valid[2]     = 1'b1;
        bus.in_data[23:16]  = 8'd20;
        bus.out_ready       = 1'b0;
        next_cycle();
        for (int k = 0; k < 5; k++) begin
            check_val("stall_valid", 32'(bus.out_valid), 32'd1);
            check_val("stall_data", 32'(bus.out_data), 32'd14);
            check_val("stall_chan", 32'(bus.out_chan), 32'd2);
            check_val("stall_phase", 32'(bus.out_phase), 32'd0);
            check_val("stall_ready", 32'(bus.in_ready), 32'd0);
            check_val("stall_busy", 32'(bus.busy), 32'd1);
            next_cycle();
        end
        bus.in_valid  = 4'b0000;
        bus.out_ready = 1'b1;
        next_cycle();
        check_val("stall_samp", 32'(bus.out_data), 32'd20);
        check_val("stall_sphase", 32'(bus.out_phase), 32'd1);
        next_cycle();
        check_val("stall_done", 32'(bus.out_valid), 32'd0);

        // Width boundary on ch3 (prev[3]=8)
        send(3, 8'd255, 8'd131);
        send(3, 8'd255, 8'd255);
        send(3, 8'd0, 8'd127);

        // Reset in SAMP discards the pending sample
        apply_reset();
        bus.in_valid        = 4'b0010;
        bus.in_data[15:8]   = 8'd60;
        next_cycle();
        bus.in_valid = 4'b0000;
        check_val("r34_mid", 32'(bus.out_data), 32'd30);
        next_cycle();
        check_val("r34_samp", 32'(bus.out_phase), 32'd1);
        reset = 1'b1;
        #1;
        check_val("r34_ready", 32'(bus.in_ready), 32'd0);
        next_cycle();
        check_val("r34_valid", 32'(bus.out_valid), 32'd0);
        check_val("r34_busy", 32'(bus.busy), 32'd0);
        reset = 1'b0;
        send(1, 8'd10, 8'd5);

        // Channel isolation
        apply_reset();
        send(1, 8'd40, 8'd20);
        send(3, 8'd200, 8'd100);
        send(1, 8'd80, 8'd60);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
